target_tracker: RTL and testbench

//  Producer side of the HUD tracking interface. Consumes the per-pixel QQVGA motion-mask stream.

---
 rtl/topgun_pkg.sv | 25 ++
 rtl/seq_divider.sv | 77 +++++++
 rtl/target_tracker.sv | 249 ++++++++++++++++++++++++
 tb/tb_target_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/topgun_pkg.sv
// Shared constants and state encodings for the HUD target tracker.
package topgun_pkg;

    localparam int QQVGA_W = 160;
    localparam int QQVGA_H = 120;
    localparam int SUM_W   = 22;
    localparam int CNT_W   = 15;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SNAP,
        DIV_X,
        DIV_Y,
        UPDATE
    } frame_state_t;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED,
        COAST
    } lock_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done pulses N_W cycles after start.
module seq_divider #(
    parameter int N_W = 22,
    parameter int D_W = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N_W-1:0] numer,
    input  logic [D_W-1:0] denom,
    output logic [N_W-1:0] quotient,
    output logic           done
);

    localparam int CNT_BITS = $clog2(N_W + 1);

    logic [D_W-1:0]      rem_reg;
    logic [N_W-1:0]      quo_reg;
    logic [D_W-1:0]      den_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic                active_reg;
    logic                done_reg;

    logic [D_W-1:0] cur_rem;
    logic [N_W-1:0] cur_quo;
    logic [D_W-1:0] cur_den;
    logic [D_W:0]   trial;
    logic [D_W:0]   diff;
    logic           fits;
    logic [D_W-1:0] rem_step;
    logic [N_W-1:0] quo_step;

    // quo_reg shifts numerator bits out of the top while quotient bits enter at the bottom
    always_comb begin
        cur_rem  = start ? '0 : rem_reg;
        cur_quo  = start ? numer : quo_reg;
        cur_den  = start ? denom : den_reg;
        trial    = {cur_rem, cur_quo[N_W-1]};
        diff     = trial - {1'b0, cur_den};
        fits     = (trial >= {1'b0, cur_den});
        rem_step = fits ? diff[D_W-1:0] : trial[D_W-1:0];
        quo_step = {cur_quo[N_W-2:0], fits};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg    <= '0;
            quo_reg    <= '0;
            den_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg    <= rem_step;
                quo_reg    <= quo_step;
                den_reg    <= denom;
                cnt_reg    <= CNT_BITS'(N_W - 1);
                active_reg <= 1'b1;
            end else if (active_reg) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg - CNT_BITS'(1);
                if (cnt_reg == CNT_BITS'(1)) begin
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_reg;
    assign done     = done_reg;

endmodule

// File: rtl/target_tracker.sv
// Per-frame motion blob accumulator with centroid divide and lock-on state
// machine; all published results change together in the UPDATE cycle.
module target_tracker
    import topgun_pkg::*;
#(
    parameter int MIN_PIXELS  = 16,
    parameter int LOCK_FRAMES = 3,
    parameter int LOST_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [6:0] pix_y,
    input  logic       motion_mask,
    output logic [7:0] target_x,
    output logic [6:0] target_y,
    output logic       target_valid,
    output logic [7:0] box_x_min,
    output logic [7:0] box_x_max,
    output logic [6:0] box_y_min,
    output logic [6:0] box_y_max,
    output logic       box_valid,
    output logic       busy
);

    localparam int HIT_W  = $clog2(LOCK_FRAMES + 1);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    frame_state_t state_reg;
    lock_state_t  lock_reg, lock_next;
    logic [HIT_W-1:0]  hits_reg, hits_next;
    logic [MISS_W-1:0] misses_reg, misses_next;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SUM_W-1:0] sum_x_reg, sum_x_next;
    logic [SUM_W-1:0] sum_y_reg, sum_y_next;
    logic [7:0]       x_min_reg, x_min_next, x_max_reg, x_max_next;
    logic [6:0]       y_min_reg, y_min_next, y_max_reg, y_max_next;
    logic             frame_open_reg;

    logic [CNT_W-1:0] snap_cnt_reg;
    logic [SUM_W-1:0] snap_sum_x_reg, snap_sum_y_reg;
    logic [7:0]       snap_x_min_reg, snap_x_max_reg;
    logic [6:0]       snap_y_min_reg, snap_y_max_reg;
    logic             snap_det_reg;
    logic [7:0]       qx_reg;

    logic             pix_ok;
    logic             end_accept;
    logic             div_start;
    logic [SUM_W-1:0] div_numer;
    logic [SUM_W-1:0] div_quotient;
    logic             div_done;
    logic             unused_quo_hi;

    assign pix_ok     = pix_valid && motion_mask && (pix_x < 8'(QQVGA_W)) && (pix_y < 7'(QQVGA_H));
    assign end_accept = (state_reg == ACCUM) && frame_end;

    // A pixel sharing the frame_start slot lands in the freshly cleared accumulators
    always_comb begin
        cnt_next   = cnt_reg;
        sum_x_next = sum_x_reg;
        sum_y_next = sum_y_reg;
        x_min_next = x_min_reg;
        x_max_next = x_max_reg;
        y_min_next = y_min_reg;
        y_max_next = y_max_reg;
        if (frame_start) begin
            cnt_next   = '0;
            sum_x_next = '0;
            sum_y_next = '0;
            x_min_next = '1;
            x_max_next = '0;
            y_min_next = '1;
            y_max_next = '0;
        end
        if ((frame_start || frame_open_reg) && pix_ok) begin
            cnt_next   = cnt_next + CNT_W'(1);
            sum_x_next = sum_x_next + SUM_W'(pix_x);
            sum_y_next = sum_y_next + SUM_W'(pix_y);
            if (pix_x < x_min_next) x_min_next = pix_x;
            if (pix_x > x_max_next) x_max_next = pix_x;
            if (pix_y < y_min_next) y_min_next = pix_y;
            if (pix_y > y_max_next) y_max_next = pix_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            sum_x_reg      <= '0;
            sum_y_reg      <= '0;
            x_min_reg      <= '0;
            x_max_reg      <= '0;
            y_min_reg      <= '0;
            y_max_reg      <= '0;
            frame_open_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            sum_x_reg <= sum_x_next;
            sum_y_reg <= sum_y_next;
            x_min_reg <= x_min_next;
            x_max_reg <= x_max_next;
            y_min_reg <= y_min_next;
            y_max_reg <= y_max_next;
            if (frame_start)
                frame_open_reg <= 1'b1;
            else if (end_accept)
                frame_open_reg <= 1'b0;
        end
    end

    always_comb begin
        lock_next   = lock_reg;
        hits_next   = hits_reg;
        misses_next = misses_reg;
        case (lock_reg)
            SEARCH: begin
                if (snap_det_reg) begin
                    lock_next = ACQUIRE;
                    hits_next = HIT_W'(1);
                end
            end
            ACQUIRE: begin
                if (!snap_det_reg)
                    lock_next = SEARCH;
                else if (int'(hits_reg) + 1 >= LOCK_FRAMES)
                    lock_next = LOCKED;
                else
                    hits_next = hits_reg + HIT_W'(1);
            end
            LOCKED: begin
                if (!snap_det_reg) begin
                    lock_next   = COAST;
                    misses_next = MISS_W'(1);
                end
            end
            COAST: begin
                if (snap_det_reg)
                    lock_next = LOCKED;
                else if (int'(misses_reg) + 1 >= LOST_FRAMES)
                    lock_next = SEARCH;
                else
                    misses_next = misses_reg + MISS_W'(1);
            end
            default: lock_next = SEARCH;
        endcase
    end

    assign div_start = ((state_reg == SNAP) && snap_det_reg) || ((state_reg == DIV_X) && div_done);
    assign div_numer = (state_reg == SNAP) ? snap_sum_x_reg : snap_sum_y_reg;

    seq_divider #(
        .N_W(SUM_W),
        .D_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .numer    (div_numer),
        .denom    (snap_cnt_reg),
        .quotient (div_quotient),
        .done     (div_done)
    );

    assign unused_quo_hi = ^div_quotient[SUM_W-1:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            lock_reg       <= SEARCH;
            hits_reg       <= '0;
            misses_reg     <= '0;
            snap_cnt_reg   <= '0;
            snap_sum_x_reg <= '0;
            snap_sum_y_reg <= '0;
            snap_x_min_reg <= '0;
            snap_x_max_reg <= '0;
            snap_y_min_reg <= '0;
            snap_y_max_reg <= '0;
            snap_det_reg   <= 1'b0;
            qx_reg         <= '0;
            target_x       <= '0;
            target_y       <= '0;
            target_valid   <= 1'b0;
            box_x_min      <= '0;
            box_x_max      <= '0;
            box_y_min      <= '0;
            box_y_max      <= '0;
            box_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_start) state_reg <= ACCUM;
                end
                ACCUM: begin
                    if (frame_end) begin
                        snap_cnt_reg   <= cnt_next;
                        snap_sum_x_reg <= sum_x_next;
                        snap_sum_y_reg <= sum_y_next;
                        snap_x_min_reg <= x_min_next;
                        snap_x_max_reg <= x_max_next;
                        snap_y_min_reg <= y_min_next;
                        snap_y_max_reg <= y_max_next;
                        snap_det_reg   <= (cnt_next >= CNT_W'(MIN_PIXELS));
                        busy           <= 1'b1;
                        state_reg      <= SNAP;
                    end
                end
                SNAP: begin
                    state_reg <= snap_det_reg ? DIV_X : UPDATE;
                end
                DIV_X: begin
                    if (div_done) begin
                        qx_reg    <= div_quotient[7:0];
                        state_reg <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) state_reg <= UPDATE;
                end
                UPDATE: begin
                    if (snap_det_reg) begin
                        target_x  <= qx_reg;
                        target_y  <= div_quotient[6:0];
                        box_x_min <= snap_x_min_reg;
                        box_x_max <= snap_x_max_reg;
                        box_y_min <= snap_y_min_reg;
                        box_y_max <= snap_y_max_reg;
                    end
                    box_valid    <= snap_det_reg;
                    lock_reg     <= lock_next;
                    hits_reg     <= hits_next;
                    misses_reg   <= misses_next;
                    target_valid <= (lock_next == LOCKED) || (lock_next == COAST);
                    busy         <= 1'b0;
                    // a frame opened while busy resumes straight into accumulation
                    state_reg    <= (frame_open_reg || frame_start) ? ACCUM : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench: frames are modelled as they are driven, expected results are
// queued and compared when busy falls after each UPDATE.
module tb_target_tracker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_x = '0;
    logic [6:0] pix_y = '0;
    logic       motion_mask = 1'b0;
    logic [7:0] target_x;
    logic [6:0] target_y;
    logic       target_valid;
    logic [7:0] box_x_min;
    logic [7:0] box_x_max;
    logic [6:0] box_y_min;
    logic [6:0] box_y_max;
    logic       box_valid;
    logic       busy;

    target_tracker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .motion_mask  (motion_mask),
        .target_x     (target_x),
        .target_y     (target_y),
        .target_valid (target_valid),
        .box_x_min    (box_x_min),
        .box_x_max    (box_x_max),
        .box_y_min    (box_y_min),
        .box_y_max    (box_y_max),
        .box_valid    (box_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fe_cyc; int lat; int bv; int tv;
        int tx; int ty; int xmn; int xmx; int ymn; int ymx;
    } exp_t;

    typedef struct { int x; int y; int v; int m; } pix_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_prev = 0;

    // spec-level reference state: published outputs and lock FSM
    int m_tx = 0, m_ty = 0, m_xmn = 0, m_xmx = 0, m_ymn = 0, m_ymx = 0;
    int m_lk = 0, m_hits = 0, m_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_tx = 0; m_ty = 0; m_xmn = 0; m_xmx = 0; m_ymn = 0; m_ymx = 0;
        m_lk = 0; m_hits = 0; m_miss = 0;
    endtask

    // Rectangle x0..x1 / y0..y1 in raster order; only the first 'limit' pixels are masked (limit<0: all).
    task automatic send_frame(input int x0, input int x1, input int y0, input int y1, input int limit);
        pix_t q[$];
        pix_t junk[4];
        pix_t p;
        exp_t e;
        int n = 0, cnt = 0, sx = 0, sy = 0;
        int xmn = 255, xmx = 0, ymn = 127, ymx = 0;
        int det;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                p.x = x; p.y = y; p.v = 1;
                p.m = (limit < 0 || n < limit) ? 1 : 0;
                n++;
                q.push_back(p);
            end
        junk[0] = '{200, 5, 1, 1};
        junk[1] = '{10, 10, 1, 0};
        junk[2] = '{5, 125, 1, 1};
        junk[3] = '{20, 20, 0, 1};
        for (int j = 0; j < 4; j++)
            q.insert((q.size() > 0) ? 1 : 0, junk[j]);
        foreach (q[i]) begin
            if (q[i].v == 1 && q[i].m == 1 && q[i].x < 160 && q[i].y < 120) begin
                cnt++; sx += q[i].x; sy += q[i].y;
                if (q[i].x < xmn) xmn = q[i].x;
                if (q[i].x > xmx) xmx = q[i].x;
                if (q[i].y < ymn) ymn = q[i].y;
                if (q[i].y > ymx) ymx = q[i].y;
            end
        end
        det = (cnt >= 16) ? 1 : 0;
        if (det == 1) begin
            m_tx = sx / cnt; m_ty = sy / cnt;
            m_xmn = xmn; m_xmx = xmx; m_ymn = ymn; m_ymx = ymx;
            case (m_lk)
                0: begin m_lk = 1; m_hits = 1; end
                1: begin m_hits++; if (m_hits >= 3) m_lk = 2; end
                3: m_lk = 2;
                default: ;
            endcase
        end else begin
            case (m_lk)
                1: m_lk = 0;
                2: begin m_lk = 3; m_miss = 1; end
                3: begin m_miss++; if (m_miss >= 4) m_lk = 0; end
                default: ;
            endcase
        end
        e.lat = (det == 1) ? 46 : 2;
        e.bv = det; e.tv = (m_lk >= 2) ? 1 : 0;
        e.tx = m_tx; e.ty = m_ty; e.xmn = m_xmn; e.xmx = m_xmx; e.ymn = m_ymn; e.ymx = m_ymx;
        for (int i = 0; i < q.size(); i++) begin
            p = q[i];
            frame_start = (i == 0);
            frame_end   = (i == q.size() - 1);
            pix_valid   = p.v[0];
            pix_x       = p.x[7:0];
            pix_y       = p.y[6:0];
            motion_mask = p.m[0];
            if (i == q.size() - 1) begin
                e.fe_cyc = cyc + 1;
                sb.push_back(e);
            end
            tick();
        end
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0; motion_mask = 1'b0;
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy == 1'b0 && sb.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("idle_within_bound", ok, 1);
        if (ok == 0) sb.delete();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_target_x"}, int'(target_x), 0);
        chk({tag, "_target_y"}, int'(target_y), 0);
        chk({tag, "_target_valid"}, int'(target_valid), 0);
        chk({tag, "_box_x_min"}, int'(box_x_min), 0);
        chk({tag, "_box_x_max"}, int'(box_x_max), 0);
        chk({tag, "_box_y_min"}, int'(box_y_min), 0);
        chk({tag, "_box_y_max"}, int'(box_y_max), 0);
        chk({tag, "_box_valid"}, int'(box_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Output monitor: each busy fall is one UPDATE and must match the oldest queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_prev = 0;
        end else begin
            if (busy_prev == 1 && busy == 1'b0) begin
                chk("update_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("update fe@%0d lat=%0d tgt=%0d/%0d box=%0d/%0d/%0d/%0d bv=%0d tv=%0d",
                             e.fe_cyc, cyc - e.fe_cyc, target_x, target_y, box_x_min, box_x_max,
                             box_y_min, box_y_max, box_valid, target_valid);
                    chk("latency", cyc - e.fe_cyc, e.lat);
                    chk("box_valid", int'(box_valid), e.bv);
                    chk("target_valid", int'(target_valid), e.tv);
                    chk("target_x", int'(target_x), e.tx);
                    chk("target_y", int'(target_y), e.ty);
                    chk("box_x_min", int'(box_x_min), e.xmn);
                    chk("box_x_max", int'(box_x_max), e.xmx);
                    chk("box_y_min", int'(box_y_min), e.ymn);
                    chk("box_y_max", int'(box_y_max), e.ymx);
                end
            end
            busy_prev = int'(busy);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();
        tick();

        // single 10x10 blob
        send_frame(40, 49, 30, 39, -1);
        wait_idle();
        // two more hits: lock on the third
        send_frame(40, 49, 30, 39, -1);
        wait_idle();
        send_frame(40, 49, 30, 39, -1);
        wait_idle();
        // four empty frames: coast three times, drop on the fourth
        for (int k = 0; k < 4; k++) begin
            send_frame(0, -1, 0, -1, -1);
            wait_idle();
        end
        // two hits then a miss never locks
        send_frame(40, 49, 30, 39, -1);
        wait_idle();
        send_frame(40, 49, 30, 39, -1);
        wait_idle();
        send_frame(0, -1, 0, -1, -1);
        wait_idle();
        // detection threshold: 15 pixels miss, 16 pixels hit
        send_frame(100, 107, 50, 51, 15);
        wait_idle();
        send_frame(100, 107, 50, 51, 16);
        wait_idle();

        // frame_end with no open frame is ignored
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        chk("orphan_end_busy", int'(busy), 0);
        tick();

        // next frame starts 10 cycles after frame_end; a stray frame_end lands while busy
        send_frame(60, 69, 20, 29, -1);
        for (int k = 0; k < 9; k++) begin
            frame_end = (k == 3);
            tick();
        end
        frame_end = 1'b0;
        send_frame(100, 109, 80, 89, -1);
        wait_idle();

        // reset in the middle of DIV_X
        send_frame(40, 49, 30, 39, -1);
        repeat (10) tick();
        chk("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        send_frame(40, 49, 30, 39, -1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
